// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing the SDRAM controller application port among NREQ requesters.
// Serialises whole bursts and routes write strobes / read valids to the current owner.
module sdrc_app_arb #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned APP_AW = 26,
    parameter int unsigned dw     = 32,
    parameter int unsigned bl     = 9
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_resetn,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*APP_AW-1:0]   req_addr_i,
    input  logic [NREQ*bl-1:0]       req_len_i,
    input  logic [NREQ-1:0]          req_wr_n_i,
    output logic [NREQ-1:0]          req_ack_o,
    input  logic [NREQ*dw-1:0]       wr_data_i,
    input  logic [NREQ*(dw/8)-1:0]   wr_en_n_i,
    output logic [NREQ-1:0]          wr_next_o,
    output logic [dw-1:0]            rd_data_o,
    output logic [NREQ-1:0]          rd_valid_o,
    output logic [NREQ-1:0]          last_o,
    output logic                     app_req,
    output logic [APP_AW-1:0]        app_req_addr,
    output logic [bl-1:0]            app_req_len,
    output logic                     app_req_wr_n,
    input  logic                     app_req_ack,
    output logic [dw-1:0]            app_wr_data,
    output logic [dw/8-1:0]          app_wr_en_n,
    input  logic                     app_wr_next_req,
    input  logic                     app_rd_valid,
    input  logic                     app_last_rd,
    input  logic                     app_last_wr,
    input  logic [dw-1:0]            app_rd_data,
    output logic [1:0]               grant_id,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned BW = dw / 8;

    typedef enum logic [1:0] {IDLE, REQ, WR, RD} state_t;

    state_t              state, state_nxt;
    logic [1:0]          rr_ptr;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [APP_AW-1:0]   pick_addr;
    logic [bl-1:0]       pick_len;
    logic                pick_wr_n;
    logic                strobe_err;

    // Two passes: first requester at or above rr_ptr, otherwise wrap to the lowest one.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_valid && req_i[k] && (k >= 32'(rr_ptr))) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(k);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_valid && req_i[k]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(k);
            end
        end
        pick_addr = '0;
        pick_len  = '0;
        pick_wr_n = 1'b1;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_idx == 2'(k)) begin
                pick_addr = req_addr_i[k*APP_AW +: APP_AW];
                pick_len  = req_len_i[k*bl +: bl];
                pick_wr_n = req_wr_n_i[k];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        app_req     = 1'b0;
        app_wr_data = '0;
        app_wr_en_n = '1;
        req_ack_o   = '0;
        wr_next_o   = '0;
        rd_valid_o  = '0;
        last_o      = '0;
        case (state)
            IDLE: if (pick_valid) state_nxt = REQ;
            REQ: begin
                app_req = 1'b1;
                if (app_req_ack) state_nxt = app_req_wr_n ? RD : WR;
            end
            WR: if (app_last_wr) state_nxt = IDLE;
            RD: if (app_last_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_id == 2'(k)) begin
                req_ack_o[k]  = (state == REQ) && app_req_ack;
                wr_next_o[k]  = (state == WR) && app_wr_next_req;
                rd_valid_o[k] = (state == RD) && app_rd_valid;
                last_o[k]     = ((state == WR) && app_last_wr) || ((state == RD) && app_last_rd);
                if (state == WR) begin
                    app_wr_data = wr_data_i[k*dw +: dw];
                    app_wr_en_n = wr_en_n_i[k*BW +: BW];
                end
            end
        end
    end

    assign rd_data_o  = app_rd_data;
    assign busy       = (state != IDLE);
    assign strobe_err = ((app_wr_next_req || app_last_wr) && (state != WR)) ||
                        ((app_rd_valid || app_last_rd) && (state != RD));

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b1;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && pick_valid) begin
                grant_id     <= pick_idx;
                app_req_addr <= pick_addr;
                app_req_len  <= pick_len;
                app_req_wr_n <= pick_wr_n;
            end
            if ((state == REQ) && app_req_ack)
                rr_ptr <= (grant_id == 2'(NREQ - 1)) ? 2'd0 : grant_id + 2'd1;
            if (strobe_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdrc_app_arb.sv
// Directed self-checking bench for sdrc_app_arb with NREQ=2: inputs change on the
// falling edge, outputs are sampled 1ns later.
module tb_sdrc_app_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 26;
  localparam int unsigned DW   = 32;
  localparam int unsigned BL   = 9;

  logic                   sdram_clk;
  logic                   sdram_resetn;
  logic [NREQ-1:0]        req_i;
  logic [NREQ*AW-1:0]     req_addr_i;
  logic [NREQ*BL-1:0]     req_len_i;
  logic [NREQ-1:0]        req_wr_n_i;
  logic [NREQ-1:0]        req_ack_o;
  logic [NREQ*DW-1:0]     wr_data_i;
  logic [NREQ*DW/8-1:0]   wr_en_n_i;
  logic [NREQ-1:0]        wr_next_o;
  logic [DW-1:0]          rd_data_o;
  logic [NREQ-1:0]        rd_valid_o;
  logic [NREQ-1:0]        last_o;
  logic                   app_req;
  logic [AW-1:0]          app_req_addr;
  logic [BL-1:0]          app_req_len;
  logic                   app_req_wr_n;
  logic                   app_req_ack;
  logic [DW-1:0]          app_wr_data;
  logic [DW/8-1:0]        app_wr_en_n;
  logic                   app_wr_next_req;
  logic                   app_rd_valid;
  logic                   app_last_rd;
  logic                   app_last_wr;
  logic [DW-1:0]          app_rd_data;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   err;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  sdrc_app_arb #(.NREQ(NREQ), .APP_AW(AW), .dw(DW), .bl(BL)) dut (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_wr_n_i(req_wr_n_i), .req_ack_o(req_ack_o),
    .wr_data_i(wr_data_i), .wr_en_n_i(wr_en_n_i), .wr_next_o(wr_next_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .last_o(last_o),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_rd_valid(app_rd_valid),
    .app_last_rd(app_last_rd), .app_last_wr(app_last_wr),
    .app_rd_data(app_rd_data), .grant_id(grant_id), .busy(busy), .err(err)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  task automatic check(input string tag, input logic ok);
    checks++;
    if (ok === 1'b1) passed++;
    else begin
      failed++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick;
    @(negedge sdram_clk);
  endtask

  task automatic clear_strobes;
    app_req_ack     = 1'b0;
    app_wr_next_req = 1'b0;
    app_last_wr     = 1'b0;
    app_rd_valid    = 1'b0;
    app_last_rd     = 1'b0;
  endtask

  int n_app, n_a, n_b, n_last, exp_id;

  initial begin
    sdram_resetn = 1'b0;
    req_i = '0; req_addr_i = '0; req_len_i = '0; req_wr_n_i = '1;
    wr_data_i = '0; wr_en_n_i = '1; app_rd_data = '0;
    clear_strobes();

    tick(); #1;
    check("rst_app_req", app_req === 1'b0);
    check("rst_wr_n", app_req_wr_n === 1'b1);
    check("rst_addr", app_req_addr === '0);
    check("rst_en_n", app_wr_en_n === 4'hF);
    check("rst_busy", busy === 1'b0);
    check("rst_err", err === 1'b0);
    check("rst_grant", grant_id === 2'd0);
    check("rst_ack", req_ack_o === 2'b00);
    tick(); sdram_resetn = 1'b1;

    tick();
    req_i = 2'b01;
    req_addr_i[0 +: AW] = 26'h000100; req_len_i[0 +: BL] = 9'd4; req_wr_n_i[0] = 1'b0;
    wr_data_i[0 +: DW] = 32'hA5A5_0001; wr_en_n_i[0 +: 4] = 4'h0;
    wr_data_i[DW +: DW] = 32'h5A5A_FFFF; wr_en_n_i[4 +: 4] = 4'hC;
    #1 check("w_busy_idle", busy === 1'b0);
    n_app = 0;
    for (int c = 0; c < 3; c++) begin
      tick(); app_req_ack = (c == 2); #1;
      if (app_req) n_app++;
    end
    check("w_ack", req_ack_o === 2'b01);
    check("w_app_req_cycles", n_app === 3);
    check("w_addr", app_req_addr === 26'h000100);
    check("w_len", app_req_len === 9'd4);
    check("w_dir", app_req_wr_n === 1'b0);
    check("w_grant", grant_id === 2'd0);
    tick(); app_req_ack = 1'b0; req_i = '0; #1;
    check("w_app_req_low", app_req === 1'b0);
    check("w_data_mux", app_wr_data === 32'hA5A5_0001);
    check("w_en_mux", app_wr_en_n === 4'h0);
    n_a = 0; n_b = 0; n_last = 0;
    for (int b = 0; b < 4; b++) begin
      tick(); app_wr_next_req = 1'b1; app_last_wr = (b == 3); #1;
      n_a += int'(wr_next_o[0]); n_b += int'(wr_next_o[1]); n_last += int'(last_o[0]);
    end
    tick(); clear_strobes(); #1;
    check("w_next0_cnt", n_a === 4);
    check("w_next1_cnt", n_b === 0);
    check("w_last_cnt", n_last === 1);
    check("w_idle_after", busy === 1'b0);
    check("w_en_idle", app_wr_en_n === 4'hF);
    check("w_data_idle", app_wr_data === '0);
    check("w_err", err === 1'b0);

    req_i = 2'b10;
    req_addr_i[AW +: AW] = 26'h002000; req_len_i[BL +: BL] = 9'd8; req_wr_n_i[1] = 1'b1;
    tick(); #1;
    check("r_grant", grant_id === 2'd1);
    check("r_len", app_req_len === 9'd8);
    check("r_dir", app_req_wr_n === 1'b1);
    app_req_ack = 1'b1; #1;
    check("r_ack", req_ack_o === 2'b10);
    n_a = 0; n_b = 0; n_last = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); app_req_ack = 1'b0; req_i = '0;
      app_rd_valid = 1'b1; app_rd_data = 32'hC0DE_0000 + 32'(i); app_last_rd = (i == 7); #1;
      check("r_data", rd_data_o === 32'hC0DE_0000 + 32'(i));
      n_a += int'(rd_valid_o[0]); n_b += int'(rd_valid_o[1]); n_last += int'(last_o[1]);
    end
    tick(); clear_strobes(); #1;
    check("r_valid1_cnt", n_b === 8);
    check("r_valid0_cnt", n_a === 0);
    check("r_last_cnt", n_last === 1);
    check("r_idle_after", busy === 1'b0);

    req_i = 2'b11;
    req_addr_i[0 +: AW] = 26'h000111; req_len_i[0 +: BL] = 9'd16; req_wr_n_i[0] = 1'b0;
    req_addr_i[AW +: AW] = 26'h000222; req_len_i[BL +: BL] = 9'd0; req_wr_n_i[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_id = b % 2;
      #1 check("c_idle", busy === 1'b0);
      tick(); #1;
      check("c_grant", grant_id === 2'(exp_id));
      check("c_app_req", app_req === 1'b1);
      check("c_addr", app_req_addr === ((exp_id == 1) ? 26'h000222 : 26'h000111));
      if (exp_id == 1) check("c_len_zero", app_req_len === 9'd0);
      app_req_ack = 1'b1; #1;
      check("c_ack", req_ack_o === ((exp_id == 1) ? 2'b10 : 2'b01));
      tick(); app_req_ack = 1'b0;
      if (exp_id == 0) begin
        app_wr_next_req = 1'b1; app_last_wr = 1'b1;
      end else begin
        app_rd_valid = 1'b1; app_last_rd = 1'b1;
      end
      #1 check("c_last", last_o === ((exp_id == 1) ? 2'b10 : 2'b01));
      tick(); clear_strobes();
    end
    req_i = '0;

    req_i = 2'b01;
    req_addr_i[0 +: AW] = 26'h0ABCDE; req_len_i[0 +: BL] = 9'd7; req_wr_n_i[0] = 1'b1;
    tick();
    req_i = '0; req_addr_i[0 +: AW] = 26'h3FFFFFF; req_len_i[0 +: BL] = 9'd1;
    #1 check("wd_req_held", app_req === 1'b1);
    tick(); #1;
    check("wd_req_held2", app_req === 1'b1);
    check("wd_addr", app_req_addr === 26'h0ABCDE);
    check("wd_len", app_req_len === 9'd7);
    app_req_ack = 1'b1; #1;
    check("wd_ack", req_ack_o === 2'b01);
    tick(); app_req_ack = 1'b0; app_rd_valid = 1'b1; app_last_rd = 1'b1; #1;
    check("wd_valid", rd_valid_o === 2'b01);
    check("wd_last", last_o === 2'b01);
    tick(); clear_strobes(); #1;
    check("wd_idle", busy === 1'b0);

    tick(); app_rd_valid = 1'b1; #1;
    check("sp_no_valid", rd_valid_o === 2'b00);
    check("sp_err_pre", err === 1'b0);
    tick(); app_rd_valid = 1'b0; #1;
    check("sp_err_set", err === 1'b1);
    tick(); tick(); #1;
    check("sp_err_sticky", err === 1'b1);

    req_i = 2'b01;
    req_addr_i[0 +: AW] = 26'h000155; req_len_i[0 +: BL] = 9'd8; req_wr_n_i[0] = 1'b1;
    tick(); app_req_ack = 1'b1; #1;
    check("mr_ack", req_ack_o === 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick(); app_req_ack = 1'b0; req_i = '0; app_rd_valid = 1'b1; app_rd_data = 32'(i);
    end
    tick(); app_rd_valid = 1'b0; sdram_resetn = 1'b0; #1;
    check("mr_busy", busy === 1'b0);
    check("mr_app_req", app_req === 1'b0);
    check("mr_err", err === 1'b0);
    check("mr_addr", app_req_addr === '0);
    check("mr_len", app_req_len === '0);
    check("mr_wr_n", app_req_wr_n === 1'b1);
    check("mr_en_n", app_wr_en_n === 4'hF);
    check("mr_last", last_o === 2'b00);
    tick(); sdram_resetn = 1'b1;

    req_i = 2'b11;
    req_addr_i[0 +: AW] = 26'h000044; req_wr_n_i[0] = 1'b1;
    req_addr_i[AW +: AW] = 26'h003333; req_len_i[BL +: BL] = 9'd2; req_wr_n_i[1] = 1'b0;
    wr_data_i[DW +: DW] = 32'hDEAD_BEEF; wr_en_n_i[4 +: 4] = 4'h5;
    tick(); #1;
    check("pr_grant0", grant_id === 2'd0);
    app_req_ack = 1'b1; #1;
    check("pr_ack0", req_ack_o === 2'b01);
    tick(); app_req_ack = 1'b0; req_i = 2'b10; app_rd_valid = 1'b1; app_last_rd = 1'b1;
    tick(); clear_strobes();

    tick(); #1;
    check("pr_grant1", grant_id === 2'd1);
    check("pr_addr1", app_req_addr === 26'h003333);
    check("pr_dir1", app_req_wr_n === 1'b0);
    app_req_ack = 1'b1; #1;
    check("pr_ack1", req_ack_o === 2'b10);
    tick(); app_req_ack = 1'b0; req_i = '0; #1;
    check("pr_data1", app_wr_data === 32'hDEAD_BEEF);
    check("pr_en1", app_wr_en_n === 4'h5);
    for (int b = 0; b < 2; b++) begin
      tick(); app_wr_next_req = 1'b1; app_last_wr = (b == 1); #1;
      check("pr_next1", wr_next_o === 2'b10);
    end
    check("pr_last1", last_o === 2'b10);
    tick(); clear_strobes(); #1;
    check("pr_idle", busy === 1'b0);
    check("pr_err", err === 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sdrc_app_arb.md
# sdrc_app_arb

Round-robin arbiter that shares the single application request port of the SDRAM controller core among NREQ independent requesters. It sits between the requesters (bus bridges, DMA engines) and the core's app_* handshake. It serialises whole burst transactions and latches the winner's address, length and direction. It steers write-data strobes and read-data valids back to the owning requester until the core signals the last beat.

## Interface
- NREQ, 2: number of requesters (2..4)
- APP_AW, 26: application address width
- dw, 32: application data width
- bl, 9: burst length width
- sdram_clk  in  1  controller clock; all logic on rising edge
- sdram_resetn  in  1  asynchronous, active-low reset
- req_i  in  NREQ  per-requester transfer request (level, held until ack)
- req_addr_i  in  NREQ*APP_AW  packed addresses, requester k at [k*APP_AW +: APP_AW]
- req_len_i  in  NREQ*bl  packed burst lengths
- req_wr_n_i  in  NREQ  0 = write, 1 = read
- req_ack_o  out  NREQ  one-cycle acceptance pulse to granted requester
- wr_data_i  in  NREQ*dw  packed write data
- wr_en_n_i  in  NREQ*dw/8  packed active-low byte enables
- wr_next_o  out  NREQ  write-data advance strobe, owner only
- rd_data_o  out  dw  read data, broadcast to all
- rd_valid_o  out  NREQ  read-data valid, owner only
- last_o  out  NREQ  last beat of owner's burst (read or write)
- app_req / app_req_addr / app_req_len / app_req_wr_n  out  1/APP_AW/bl/1  to core
- app_req_ack  in  1  core accepted request
- app_wr_data / app_wr_en_n  out  dw/dw/8  to core
- app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr  in  1 each  from core
- app_rd_data  in  dw  from core
- grant_id  out  2  index of current/last owner
- busy  out  1  high in any state except IDLE
- err  out  1  sticky: core data strobe seen with no matching owner state; cleared only by reset

## Operation
- FSM states: IDLE, REQ, WR, RD.
- IDLE: if any req_i is set, pick the first set bit at or after rr_ptr, wrapping modulo NREQ. Latch its addr, len and wr_n into request registers. Set grant_id and go to REQ. If no req_i is set, stay in IDLE.
- REQ: app_req=1 driven from registers. On app_req_ack:
  - pulse req_ack_o[grant_id] in the same cycle (combinational from app_req_ack).
  - set rr_ptr = (grant_id+1) mod NREQ.
  - go to WR if wr_n=0, else RD.
- WR: app_wr_data/app_wr_en_n are muxed from requester grant_id. wr_next_o[grant_id]=app_wr_next_req. On app_last_wr, last_o[grant_id]=1 and go to IDLE.
- RD: rd_valid_o[grant_id]=app_rd_valid. On app_last_rd, last_o[grant_id]=1 and go to IDLE.
- rd_data_o = app_rd_data at all times, unregistered.
- Request fields pass through unchanged, with no width conversion. len=0 is forwarded as-is.
- A requester dropping req_i after it has been latched does not cancel the grant; the transaction completes.
- Strobe errors: app_wr_next_req or app_last_wr outside WR, or app_rd_valid or app_last_rd outside RD, sets err. The strobe is not forwarded.
- Outside the owning state, app_wr_en_n is driven all-ones and app_wr_data is driven zero.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, app_req=0, app_req_addr/len=0, app_req_wr_n=1, err=0, busy=0. All per-requester outputs are 0; app_wr_en_n is all-ones.
- Reset mid-transaction returns to IDLE immediately. No completion pulse is generated.
- Request latency: req_i sampled high in IDLE at edge N gives app_req=1 from cycle N+1.
- app_req stays high until the cycle app_req_ack is seen. It is 0 from the next cycle.
- Completion: the last_* cycle is the final data cycle, and the state is IDLE the next cycle. This gives one idle/arbitration cycle between bursts, so back-to-back grants are 2 cycles apart at minimum before the next app_req.
- Simultaneous req_i: rr_ptr decides. A requester is never granted twice in a row while another is pending.
- Fairness: worst-case wait is NREQ-1 full bursts.

## Test plan
- Single write, requester 0:
  - stimulus: addr 0x000100, len 4, core acks 3 cycles after app_req, then 4 app_wr_next_req, last with the 4th.
  - response: app_req high 3 cycles; req_ack_o=01 once; wr_next_o[0] pulses 4 times; last_o[0] once; IDLE 1 cycle later.
- Contention, NREQ=2, both req_i held:
  - grants alternate 0,1,0,1 across 4 bursts; grant_id matches each app_req.
- Read routing:
  - stimulus: requester 1 reads len 8.
  - response: 8 rd_valid_o[1] pulses, rd_valid_o[0] stays 0, last_o[1] with the 8th beat, rd_data_o equals app_rd_data each beat.
- Reset mid-burst:
  - stimulus: sdramresetn low during RD after 3 beats.
  - response: all outputs at reset values asynchronously; rr_ptr=0; next req_i from requester 1 alone is granted normally.
- Spurious strobe:
  - stimulus: app_rd_valid pulsed in IDLE.
  - response: no rd_valid_o; err=1 and held until reset.
- Request withdrawal:
  - stimulus: req_i[0] dropped the cycle after latch.
  - response: app_req still held until ack; burst completes with the latched addr/len.
